// File: rtl/core_pkg.sv
// core_pkg: shared core constants and arb_mux channel index assignments
package core_pkg;
  localparam int XLEN = 32;
  localparam int CH_FETCH = 0;
  localparam int CH_LSU = 1;
  localparam int CH_DBG = 2;
endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, search starts just after ptr
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              grant_valid
);
  // scan farthest-first so the nearest requester after ptr wins last
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    for (int k = NUM_CH; k >= 1; k--)
      if (req[IDX_W'((int'(ptr) + k) % NUM_CH)]) begin
        grant = IDX_W'((int'(ptr) + k) % NUM_CH);
        grant_valid = 1'b1;
      end
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel round-robin arbitrating mux with registered output; burst lock under ARB_MUX_LOCK_EN
module arb_mux
  import core_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int NUM_CH = 4,
  parameter int IDX_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]       in_lock,
`endif
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]        out_sel,
  input  logic                    out_ready
);
  logic load_en, grant_valid, xfer;
  logic [NUM_CH-1:0] req;
  logic [IDX_W-1:0] grant, rr_ptr_q, rr_ptr_d, out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
`ifdef ARB_MUX_LOCK_EN
  logic locked_q, locked_d;
  logic [IDX_W-1:0] lock_ch_q, lock_ch_d;
  assign req = locked_q ? in_valid & (NUM_CH'(1) << lock_ch_q) : in_valid;
`else
  assign req = in_valid;
`endif
  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req(req),
    .ptr(rr_ptr_q),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  assign load_en = !out_valid_q || out_ready;
  assign xfer = load_en && grant_valid && !rst;
  assign in_ready = xfer ? NUM_CH'(1) << grant : '0;
  // load the winner, drain on consumer accept, hold under backpressure
  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d = xfer ? in_data[int'(grant)*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = xfer ? grant : out_sel_q;
    rr_ptr_d = xfer ? grant : rr_ptr_q;
`ifdef ARB_MUX_LOCK_EN
    locked_d = xfer ? in_lock[grant] : locked_q;
    lock_ch_d = xfer ? grant : lock_ch_q;
`endif
  end
  // state registers; pointer resets to the last channel so channel 0 goes first
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      rr_ptr_q <= IDX_W'(NUM_CH - 1);
`ifdef ARB_MUX_LOCK_EN
      locked_q <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef ARB_MUX_LOCK_EN
      locked_q <= locked_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: scoreboard bench for arb_mux with directed vectors
module tb_arb_mux;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] in_valid;
  logic [127:0] in_data;
  logic [3:0] in_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [3:0] in_lock;
`endif
  logic out_valid;
  logic [31:0] out_data;
  logic [1:0] out_sel;
  logic out_ready;
  typedef struct {
    logic [31:0] d;
    logic [1:0] s;
  } exp_t;
  exp_t exp_q[$];
  int pass = 0;
  int total = 0;
  always #5 clk = ~clk;
  arb_mux dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_lock(in_lock),
`endif
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic push(input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_data(input int i, input logic [31:0] v);
    in_data[i*32 +: 32] = v;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got sel %0d data %h expected none", out_sel, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sel", 32'(out_sel), 32'(e.s));
      end
    end
  end
  initial begin
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
    in_lock = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) set_data(i, 32'hA000_0000 + 32'(i));
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(in_ready), 32'b0001);
    push(32'hA000_0000, 2'd0);
    step();
    in_valid = 4'b0000;
    step();
    in_valid = 4'b0100;
    set_data(2, 32'hDEAD_BEEF);
    #1;
    chk("single_ready", 32'(in_ready), 32'b0100);
    push(32'hDEAD_BEEF, 2'd2);
    step();
    in_valid = 4'b0000;
    chk("single_valid", 32'(out_valid), 32'd1);
    step();
    in_valid = 4'b1000;
    set_data(3, 32'hC0DE_0003);
    #1;
    chk("ch3_ready", 32'(in_ready), 32'b1000);
    push(32'hC0DE_0003, 2'd3);
    step();
    in_valid = 4'b0000;
    chk("ch3_valid", 32'(out_valid), 32'd1);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 32'h1111_0000 + 32'(i));
    for (int k = 0; k < 8; k++) push(32'h1111_0000 + 32'(k % 4), 2'(k % 4));
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(in_ready), 32'(1 << (k % 4)));
      step();
    end
    in_valid = 4'b0010;
    set_data(1, 32'hB0B0_0001);
    #1;
    chk("bp_load_ready", 32'(in_ready), 32'b0010);
    push(32'hB0B0_0001, 2'd1);
    step();
    out_ready = 1'b0;
    in_valid = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_data", out_data, 32'hB0B0_0001);
      chk("bp_sel", 32'(out_sel), 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 32'b0100);
    push(32'h1111_0002, 2'd2);
    step();
    in_valid = 4'b0000;
    step();
`ifdef ARB_MUX_LOCK_EN
    in_valid = 4'b0010;
    in_lock = 4'b0010;
    set_data(1, 32'h10C0_0001);
    #1;
    chk("lock1_ready", 32'(in_ready), 32'b0010);
    push(32'h10C0_0001, 2'd1);
    step();
    in_valid = 4'b0111;
    set_data(1, 32'h10C0_0002);
    #1;
    chk("lock2_ready", 32'(in_ready), 32'b0010);
    push(32'h10C0_0002, 2'd1);
    step();
    in_lock = 4'b0000;
    set_data(1, 32'h10C0_0003);
    #1;
    chk("lock3_ready", 32'(in_ready), 32'b0010);
    push(32'h10C0_0003, 2'd1);
    step();
    in_valid = 4'b0101;
    #1;
    chk("unlock_ready", 32'(in_ready), 32'b0100);
    push(32'h1111_0002, 2'd2);
    step();
    in_valid = 4'b0000;
    step();
`endif
    out_ready = 1'b0;
    in_valid = 4'b0001;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    in_valid = 4'b0000;
    out_ready = 1'b1;
    step();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
